// File: rtl/batalha_naval_arbitro.sv
// Battleship referee: keeps both ship maps, takes alternating shots over valid/ready,
// scores hits and declares a winner or a draw after MAX_TURNS accepted shots.
module batalha_naval_arbitro #(
  parameter int unsigned                   COORD_W   = 3,
  parameter logic [(2**COORD_W)-1:0]       SHIPS_P1  = 8'b0010_0110,
  parameter logic [(2**COORD_W)-1:0]       SHIPS_P2  = 8'b1001_0001,
  parameter int unsigned                   MAX_TURNS = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   shot_valid,
  input  logic                                   shot_player,
  input  logic [COORD_W-1:0]                     shot_coord,
  output logic                                   shot_ready,
  output logic                                   res_valid,
  output logic                                   res_hit,
  output logic                                   res_repeat,
  output logic                                   out_of_turn,
  output logic                                   turn,
  output logic [$clog2((2**COORD_W)+1)-1:0]      score_p1,
  output logic [$clog2((2**COORD_W)+1)-1:0]      score_p2,
  output logic                                   game_over,
  output logic [1:0]                             winner
);
  localparam int unsigned CELLS = 2**COORD_W;
  localparam int unsigned SW    = $clog2(CELLS + 1);
  localparam int unsigned TW    = $clog2(MAX_TURNS + 1);
  localparam logic [SW-1:0] SCORE_MAX = SW'(CELLS);
  localparam logic [TW-1:0] LAST_SHOT = TW'(MAX_TURNS - 1);

  typedef enum logic [1:0] {IDLE, P1_TURN, P2_TURN, DONE} state_e;

  state_e            state_q, state_d;
  logic [CELLS-1:0]  rem_p1_q, rem_p1_d, rem_p2_q, rem_p2_d;
  logic [CELLS-1:0]  fired_p1_q, fired_p1_d, fired_p2_q, fired_p2_d;
  logic [SW-1:0]     score_p1_q, score_p1_d, score_p2_q, score_p2_d;
  logic [TW-1:0]     shots_q, shots_d;
  logic              res_valid_q, res_valid_d, res_hit_q, res_hit_d;
  logic              res_repeat_q, res_repeat_d, oot_q, oot_d;
  logic [1:0]        winner_q, winner_d;

  logic              cur_player, in_play, accept, hit;
  logic [CELLS-1:0]  opp_rem, opp_rem_next, own_fired, own_fired_next;

  always_comb begin
    state_d      = state_q;
    rem_p1_d     = rem_p1_q;
    rem_p2_d     = rem_p2_q;
    fired_p1_d   = fired_p1_q;
    fired_p2_d   = fired_p2_q;
    score_p1_d   = score_p1_q;
    score_p2_d   = score_p2_q;
    shots_d      = shots_q;
    winner_d     = winner_q;
    res_valid_d  = 1'b0;
    res_hit_d    = 1'b0;
    res_repeat_d = 1'b0;
    oot_d        = 1'b0;
    hit          = 1'b0;

    in_play    = (state_q == P1_TURN) || (state_q == P2_TURN);
    cur_player = (state_q == P2_TURN);
    accept     = in_play && shot_valid && (shot_player == cur_player);

    // Work on the shooter's view (opponent map, own fired mask), then route back.
    opp_rem        = cur_player ? rem_p1_q : rem_p2_q;
    own_fired      = cur_player ? fired_p2_q : fired_p1_q;
    opp_rem_next   = opp_rem;
    own_fired_next = own_fired;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = P1_TURN;
          rem_p1_d   = SHIPS_P1;
          rem_p2_d   = SHIPS_P2;
          fired_p1_d = '0;
          fired_p2_d = '0;
          score_p1_d = '0;
          score_p2_d = '0;
          shots_d    = '0;
          winner_d   = '0;
        end
      end
      default: begin
        if (shot_valid && !accept) begin
          oot_d = 1'b1;
        end else if (accept) begin
          res_valid_d = 1'b1;
          if (own_fired[shot_coord]) begin
            res_repeat_d = 1'b1;
          end else begin
            own_fired_next[shot_coord] = 1'b1;
            if (opp_rem[shot_coord]) begin
              hit                      = 1'b1;
              opp_rem_next[shot_coord] = 1'b0;
            end
          end
          res_hit_d = hit;
          shots_d   = shots_q + TW'(1);

          if (cur_player) begin
            fired_p2_d = own_fired_next;
            rem_p1_d   = opp_rem_next;
            if (hit && score_p2_q != SCORE_MAX) score_p2_d = score_p2_q + SW'(1);
          end else begin
            fired_p1_d = own_fired_next;
            rem_p2_d   = opp_rem_next;
            if (hit && score_p1_q != SCORE_MAX) score_p1_d = score_p1_q + SW'(1);
          end

          if (opp_rem_next == '0) begin
            state_d  = DONE;
            winner_d = cur_player ? 2'b10 : 2'b01;
          end else if (shots_q == LAST_SHOT) begin
            state_d  = DONE;
            winner_d = 2'b11;
          end else begin
            state_d = cur_player ? P1_TURN : P2_TURN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rem_p1_q     <= SHIPS_P1;
      rem_p2_q     <= SHIPS_P2;
      fired_p1_q   <= '0;
      fired_p2_q   <= '0;
      score_p1_q   <= '0;
      score_p2_q   <= '0;
      shots_q      <= '0;
      winner_q     <= '0;
      res_valid_q  <= 1'b0;
      res_hit_q    <= 1'b0;
      res_repeat_q <= 1'b0;
      oot_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_p1_q     <= rem_p1_d;
      rem_p2_q     <= rem_p2_d;
      fired_p1_q   <= fired_p1_d;
      fired_p2_q   <= fired_p2_d;
      score_p1_q   <= score_p1_d;
      score_p2_q   <= score_p2_d;
      shots_q      <= shots_d;
      winner_q     <= winner_d;
      res_valid_q  <= res_valid_d;
      res_hit_q    <= res_hit_d;
      res_repeat_q <= res_repeat_d;
      oot_q        <= oot_d;
    end
  end

  assign shot_ready  = (state_q == P1_TURN) || (state_q == P2_TURN);
  assign turn        = (state_q == P2_TURN);
  assign game_over   = (state_q == DONE);
  assign res_valid   = res_valid_q;
  assign res_hit     = res_hit_q;
  assign res_repeat  = res_repeat_q;
  assign out_of_turn = oot_q;
  assign score_p1    = score_p1_q;
  assign score_p2    = score_p2_q;
  assign winner      = winner_q;

endmodule

// File: tb/tb_batalha_naval_arbitro.sv
// Bench for batalha_naval_arbitro: directed game scenarios plus random play,
// all checked against a cell-array game model; a second instance has an empty P2 map.
module tb_batalha_naval_arbitro;
  localparam int CELLS = 8;
  localparam int MAXT  = 16;
  localparam logic [7:0] SH1 = 8'b0010_0110;
  localparam logic [7:0] SH2 = 8'b1001_0001;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic       start = 1'b0, shot_valid = 1'b0, shot_player = 1'b0;
  logic [2:0] shot_coord = '0;
  logic       shot_ready, res_valid, res_hit, res_repeat, out_of_turn, turn, game_over;
  logic [3:0] score_p1, score_p2;
  logic [1:0] winner;

  logic       z_start = 1'b0, z_valid = 1'b0;
  logic       z_ready, z_rv, z_hit, z_rep, z_oot, z_turn, z_over;
  logic [3:0] z_s1, z_s2;
  logic [1:0] z_win;

  always #5 clk = ~clk;

  batalha_naval_arbitro #(.COORD_W(3), .SHIPS_P1(SH1), .SHIPS_P2(SH2), .MAX_TURNS(MAXT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shot_valid(shot_valid),
    .shot_player(shot_player), .shot_coord(shot_coord), .shot_ready(shot_ready),
    .res_valid(res_valid), .res_hit(res_hit), .res_repeat(res_repeat),
    .out_of_turn(out_of_turn), .turn(turn), .score_p1(score_p1), .score_p2(score_p2),
    .game_over(game_over), .winner(winner));

  batalha_naval_arbitro #(.COORD_W(3), .SHIPS_P1(SH1), .SHIPS_P2(8'h00), .MAX_TURNS(MAXT)) dut_zero (
    .clk(clk), .rst_n(rst_n), .start(z_start), .shot_valid(z_valid),
    .shot_player(shot_player), .shot_coord(shot_coord), .shot_ready(z_ready),
    .res_valid(z_rv), .res_hit(z_hit), .res_repeat(z_rep),
    .out_of_turn(z_oot), .turn(z_turn), .score_p1(z_s1), .score_p2(z_s2),
    .game_over(z_over), .winner(z_win));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Game model: phase 0 idle, 1 playing, 2 finished.
  int m_phase, m_turn, m_shots, m_winner;
  int m_score[2];
  bit m_rem[2][CELLS];
  bit m_fired[2][CELLS];
  bit m_rv, m_hit, m_rep, m_oot;

  function automatic void m_load();
    for (int i = 0; i < CELLS; i++) begin
      m_rem[0][i]   = SH1[i];
      m_rem[1][i]   = SH2[i];
      m_fired[0][i] = 1'b0;
      m_fired[1][i] = 1'b0;
    end
    m_score[0] = 0; m_score[1] = 0;
    m_shots = 0; m_winner = 0; m_turn = 0;
  endfunction

  function automatic void m_reset();
    m_load();
    m_phase = 0;
    m_rv = 0; m_hit = 0; m_rep = 0; m_oot = 0;
  endfunction

  function automatic int m_left(int p);
    int n = 0;
    for (int i = 0; i < CELLS; i++) n += int'(m_rem[p][i]);
    return n;
  endfunction

  function automatic void m_step(bit st, bit v, bit pl, int c);
    int opp;
    m_rv = 0; m_hit = 0; m_rep = 0; m_oot = 0;
    if (m_phase != 1) begin
      if (st) begin m_load(); m_phase = 1; end
    end else if (v) begin
      if (int'(pl) != m_turn) m_oot = 1;
      else begin
        opp  = 1 - m_turn;
        m_rv = 1;
        if (m_fired[m_turn][c]) m_rep = 1;
        else begin
          m_fired[m_turn][c] = 1;
          if (m_rem[opp][c]) begin
            m_hit = 1;
            m_rem[opp][c] = 0;
            if (m_score[m_turn] < CELLS) m_score[m_turn]++;
          end
        end
        m_shots++;
        if (m_left(opp) == 0) begin m_phase = 2; m_winner = m_turn + 1; m_turn = 0; end
        else if (m_shots == MAXT) begin m_phase = 2; m_winner = 3; m_turn = 0; end
        else m_turn = opp;
      end
    end
  endfunction

  task automatic check_all();
    check("shot_ready",  32'(shot_ready),  32'(m_phase == 1));
    check("res_valid",   32'(res_valid),   32'(m_rv));
    check("res_hit",     32'(res_hit),     32'(m_hit));
    check("res_repeat",  32'(res_repeat),  32'(m_rep));
    check("out_of_turn", 32'(out_of_turn), 32'(m_oot));
    check("turn",        32'(turn),        32'(m_turn));
    check("score_p1",    32'(score_p1),    32'(m_score[0]));
    check("score_p2",    32'(score_p2),    32'(m_score[1]));
    check("game_over",   32'(game_over),   32'(m_phase == 2));
    check("winner",      32'(winner),      32'(m_winner));
  endtask

  task automatic tick(input bit st, input bit v, input bit pl, input int c);
    start = st; shot_valid = v; shot_player = pl; shot_coord = c[2:0];
    m_step(st, v, pl, c);
    @(posedge clk); #1;
    check_all();
    start = 1'b0; shot_valid = 1'b0;
  endtask

  // Asynchronous reset asserted mid-cycle, released one edge later.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    m_reset();
    #1 check_all();
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    m_reset();
    @(posedge clk); #1;
    check_all();
    rst_n = 1'b1;

    // Empty P2 map: P1's first shot wins even though it misses.
    z_start = 1'b1;
    tick(0, 0, 0, 2);
    z_start = 1'b0;
    check("z_ready", 32'(z_ready), 1);
    check("z_over0", 32'(z_over), 0);
    z_valid = 1'b1;
    tick(0, 0, 0, 2);
    z_valid = 1'b0;
    check("z_rv", 32'(z_rv), 1);
    check("z_hit", 32'(z_hit), 0);
    check("z_over", 32'(z_over), 1);
    check("z_win", 32'(z_win), 1);

    // First shot misses, turn passes.
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 1);
    check("t1_rv", 32'(res_valid), 1);
    check("t1_hit", 32'(res_hit), 0);
    check("t1_turn", 32'(turn), 1);

    // P1 sinks all of P2's ships.
    pulse_reset();
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0); tick(0, 1, 1, 1); tick(0, 1, 0, 4);
    tick(0, 1, 1, 2); tick(0, 1, 0, 7);
    check("t2_over", 32'(game_over), 1);
    check("t2_win", 32'(winner), 1);
    check("t2_s1", 32'(score_p1), 3);
    check("t2_s2", 32'(score_p2), 2);

    // Repeat shot, then an out-of-turn request.
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0); tick(0, 1, 1, 3); tick(0, 1, 0, 0);
    check("t3_rep", 32'(res_repeat), 1);
    check("t3_hit", 32'(res_hit), 0);
    check("t3_s1", 32'(score_p1), 1);
    tick(0, 1, 1, 3);
    tick(0, 1, 1, 5);
    check("t4_oot", 32'(out_of_turn), 1);
    check("t4_rv", 32'(res_valid), 0);
    check("t4_turn", 32'(turn), 0);

    // Draw after MAX_TURNS misses; later shots ignored; restart clears scores.
    pulse_reset();
    tick(1, 0, 0, 0);
    for (int i = 0; i < MAXT / 2; i++) begin
      tick(0, 1, 0, 3);
      tick(0, 1, 1, 0);
    end
    check("t5_win", 32'(winner), 3);
    check("t5_ready", 32'(shot_ready), 0);
    tick(0, 1, 0, 0);
    check("t5_ign", 32'(res_valid), 0);
    tick(1, 0, 0, 0);
    check("t5_s1", 32'(score_p1), 0);

    // Reset after a hit restores the maps: the same cell hits again.
    tick(0, 1, 0, 0);
    pulse_reset();
    check("t6_ready", 32'(shot_ready), 0);
    tick(1, 0, 0, 0);
    tick(0, 1, 0, 0);
    check("t6_hit", 32'(res_hit), 1);

    // Random play with occasional resets and out-of-turn requests.
    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 99) < 2) pulse_reset();
      else tick(($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 4) == 0) ? (m_turn == 0) : (m_turn == 1),
                int'($urandom_range(0, CELLS - 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
